// File: rtl/count_fifo_source_if.sv
// count_fifo_source_if: consumer-side read handshake and feeder status of the counting FIFO source.
interface count_fifo_source_if #(parameter int DATA_WIDTH = 8) ();
  logic                  r_en;
  logic [DATA_WIDTH-1:0] r_out;
  logic                  r_empty;
  logic                  w_full;
  logic                  w_en;
  logic [DATA_WIDTH-1:0] feed_count;
  modport master (input r_en, output r_out, r_empty, w_full, w_en, feed_count);
  modport slave (output r_en, input r_out, r_empty, w_full, w_en, feed_count);
endinterface

// File: rtl/count_fifo_source.sv
// count_fifo_source: counting feeder that keeps a 2^ADDR_WIDTH-entry FIFO topped up with 0,1,2,...
module count_fifo_source #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  count_fifo_source_if.master bus
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] feed_count, r_out;
  logic                  empty, full, w_en, rd;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  // rst_n gates the strobe so nothing is written while reset is held
  assign w_en  = rst_n & ~full;
  assign rd    = bus.r_en & ~empty;
  always_ff @(posedge clk)
    if (w_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= feed_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      feed_count <= '0;
      r_out      <= '0;
    end else begin
      if (w_en) begin
        wr_ptr     <= wr_ptr + 1'b1;
        feed_count <= feed_count + 1'b1;
      end
      if (rd) begin
        r_out  <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  assign bus.r_out      = r_out;
  assign bus.r_empty    = empty;
  assign bus.w_full     = full;
  assign bus.w_en       = w_en;
  assign bus.feed_count = feed_count;
endmodule

// File: tb/tb_count_fifo_source.sv
// tb_count_fifo_source: directed checks of reset, fill, streaming, start/stop, wrap and mid-stream reset.
module tb_count_fifo_source;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_v;
  logic [7:0] last;
  count_fifo_source_if #(.DATA_WIDTH(8)) bus ();
  count_fifo_source #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic test_reset();
    bus.r_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({bus.r_out, bus.r_empty, bus.w_full, bus.w_en, bus.feed_count} !== {8'h00, 1'b1, 1'b0, 1'b0, 8'h00}) begin
        bad++;
        $display("FAIL reset cyc%0d: r_out=%0h empty=%b full=%b w_en=%b feed=%0h want 0,1,0,0,0",
                 i, bus.r_out, bus.r_empty, bus.w_full, bus.w_en, bus.feed_count);
      end
    end
  endtask

  task automatic test_fill();
    bus.r_en = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++;
      if (bus.w_en !== 1'b1 || bus.feed_count !== 8'(i)) begin
        bad++;
        $display("FAIL fill edge%0d: w_en=%b feed=%0d want 1,%0d", i, bus.w_en, bus.feed_count, i);
      end
      @(negedge clk);
    end
    for (int i = 0; i <= 100; i++) begin
      total++;
      if ({bus.w_full, bus.w_en, bus.r_empty, bus.feed_count} !== {1'b1, 1'b0, 1'b0, 8'd8}) begin
        bad++;
        $display("FAIL full hold cyc%0d: full=%b w_en=%b empty=%b feed=%0d want 1,0,0,8",
                 i, bus.w_full, bus.w_en, bus.r_empty, bus.feed_count);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stream();
    bus.r_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (bus.r_out !== 8'(i) || bus.w_full !== 1'b0) begin
        bad++;
        $display("FAIL stream read%0d: r_out=%0d full=%b want %0d,0", i, bus.r_out, bus.w_full, i);
      end
    end
    exp_v = 8'd20;
    last = 8'd19;
  endtask

  task automatic test_start_stop();
    logic was_empty;
    for (int c = 0; c < 200; c++) begin
      bus.r_en = ((c / 3) % 2) == 0;
      was_empty = bus.r_empty;
      @(negedge clk);
      total++;
      if (bus.r_en && !was_empty) begin
        if (bus.r_out !== exp_v) begin
          bad++;
          $display("FAIL startstop cyc%0d: r_out=%0d want %0d", c, bus.r_out, exp_v);
        end
        last = exp_v;
        exp_v = exp_v + 8'd1;
      end else if (bus.r_out !== last) begin
        bad++;
        $display("FAIL startstop hold cyc%0d: r_out=%0d want %0d", c, bus.r_out, last);
      end
      if (!bus.r_en && (c % 3) == 2) begin
        total++;
        if (bus.w_full !== 1'b1) begin
          bad++;
          $display("FAIL refill cyc%0d: full=%b want 1", c, bus.w_full);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int wraps = 0;
    bus.r_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      total++;
      if (bus.r_out !== exp_v) begin
        bad++;
        $display("FAIL wrap read%0d: r_out=%0d want %0d", i, bus.r_out, exp_v);
      end
      if (exp_v == 8'd0) wraps++;
      exp_v = exp_v + 8'd1;
    end
    total++;
    if (wraps < 2) begin
      bad++;
      $display("FAIL wrap count: saw %0d wraps want >=2", wraps);
    end
  endtask

  task automatic test_mid_reset();
    logic was_empty;
    int n = 0;
    bus.r_en = 1'b1;
    for (int i = 0; i < 300 && bus.r_out !== 8'h37; i++) @(negedge clk);
    total++;
    if (bus.r_out !== 8'h37) begin
      bad++;
      $display("FAIL midreset reach: r_out=%0h want 37", bus.r_out);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.r_out, bus.r_empty, bus.w_full, bus.w_en, bus.feed_count} !== {8'h00, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL async reset: r_out=%0h empty=%b full=%b w_en=%b feed=%0h want 0,1,0,0,0",
               bus.r_out, bus.r_empty, bus.w_full, bus.w_en, bus.feed_count);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_v = 8'd0;
    for (int c = 0; c < 20; c++) begin
      was_empty = bus.r_empty;
      @(negedge clk);
      if (!was_empty) begin
        total++;
        if (bus.r_out !== exp_v) begin
          bad++;
          $display("FAIL after reset read%0d: r_out=%0d want %0d", n, bus.r_out, exp_v);
        end
        exp_v = exp_v + 8'd1;
        n++;
      end
    end
    total++;
    if (n < 16) begin
      bad++;
      $display("FAIL after reset count: %0d reads want >=16", n);
    end
  endtask

  initial begin
    bus.r_en = 1'b1;
    test_reset();
    test_fill();
    test_stream();
    test_start_stop();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
